// File: rtl/sp_pkg.sv
// sp_pkg: shared definitions for the serial/parallel gearbox.
//   - mode encodings carried on the mode input
//   - FSM state type
//   - beat counter width helper
package sp_pkg;

  localparam logic [1:0] MODE_S2P  = 2'b00;  // serial in, parallel out
  localparam logic [1:0] MODE_P2S  = 2'b01;  // parallel in, serial out
  localparam logic [1:0] MODE_PASS = 2'b10;  // registered pass-through
  localparam logic [1:0] MODE_REV  = 2'b11;  // registered bit-reversed pass

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Beat counter width: max(1, clog2(chunks per word)).
  function automatic int cnt_w(input int nch);
    return (nch < 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/sp_gearbox_if.sv
// sp_gearbox_if: handshake bundle of the gearbox.
//   mode/msb_first/in_data/in_valid -> in_ready : input side
//   out_data/out_valid/out_last     <- out_ready: output side
//   out_parity exists only when SP_GEARBOX_PARITY_EN is defined.
// Modports: master = producer/consumer around the block, slave = the block.
interface sp_gearbox_if #(parameter int N = 8);
  logic [1:0]   mode;
  logic         msb_first;
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
`ifdef SP_GEARBOX_PARITY_EN
  logic         out_parity;

  modport master (output mode, msb_first, in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_valid, out_last, out_parity);
  modport slave  (input  mode, msb_first, in_data, in_valid, out_ready,
                  output in_ready, out_data, out_valid, out_last, out_parity);
`else
  modport master (output mode, msb_first, in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_valid, out_last);
  modport slave  (input  mode, msb_first, in_data, in_valid, out_ready,
                  output in_ready, out_data, out_valid, out_last);
`endif
endinterface

// File: rtl/sp_bit_reverse.sv
// sp_bit_reverse: combinational bit reversal, d_o[i] = d_i[N-1-i].
//   d_i : N-bit input word
//   d_o : N-bit reversed word
module sp_bit_reverse #(
  parameter int N = 8
) (
  input  logic [N-1:0] d_i,
  output logic [N-1:0] d_o
);

  for (genvar i = 0; i < N; i++) begin : g_rev
    assign d_o[i] = d_i[N-1-i];
  end

endmodule

// File: rtl/sp_gearbox.sv
// sp_gearbox: serial<->parallel gearbox with registered pass modes.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : sp_gearbox_if.slave (mode, msb_first, in_* handshake, out_* handshake)
// Modes: S2P assembles N/L chunks of L bits into a word, P2S emits a word as
// N/L chunks on out_data[L-1:0], PASS/REV register a word (REV bit-reversed).
// Optional feature: define SP_GEARBOX_PARITY_EN to add bus.out_parity
// (XOR of the latched word while out_valid, else 0).
module sp_gearbox
  import sp_pkg::*;
#(
  parameter int N = 8,
  parameter int L = 1
) (
  input  logic          clk,
  input  logic          rst,
  sp_gearbox_if.slave   bus
);

  localparam int NCH = N / L;
  localparam int CW  = cnt_w(NCH);
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  data_q, data_d;
  logic [1:0]    mode_q, mode_d;
  logic          msb_q, msb_d;

  logic          in_rdy_w, accept_w, msb_eff_w;
  logic [CW-1:0] slot_w;
  logic [N-1:0]  ins_w, rev_w;
  logic [L-1:0]  chunk_w;

  sp_bit_reverse #(.N(N)) u_rev (
    .d_i (bus.in_data),
    .d_o (rev_w)
  );

  assign in_rdy_w = ~rst & ((state_q == IDLE) | (state_q == COLLECT));
  assign accept_w = bus.in_valid & in_rdy_w;

  // The first beat of a word is taken in IDLE, before msb_first is latched,
  // so the live input decides the chunk order there.
  assign msb_eff_w = (state_q == IDLE) ? bus.msb_first : msb_q;
  assign slot_w    = msb_eff_w ? (LAST - cnt_q) : cnt_q;

  // S2P: drop the incoming chunk into its slot; a new word starts from zero.
  always_comb begin
    ins_w = (state_q == IDLE) ? '0 : data_q;
    for (int c = 0; c < NCH; c++)
      if (CW'(c) == slot_w) ins_w[c*L +: L] = bus.in_data[L-1:0];
  end

  // P2S: chunk currently presented.
  always_comb begin
    chunk_w = '0;
    for (int c = 0; c < NCH; c++)
      if (CW'(c) == slot_w) chunk_w = data_q[c*L +: L];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mode_d  = mode_q;
    msb_d   = msb_q;
    case (state_q)
      IDLE: if (accept_w) begin
        mode_d = bus.mode;
        msb_d  = bus.msb_first;
        cnt_d  = '0;
        case (bus.mode)
          MODE_S2P: begin
            data_d  = ins_w;
            cnt_d   = CW'(1);
            state_d = COLLECT;
          end
          MODE_P2S: begin
            data_d  = bus.in_data;
            state_d = EMIT;
          end
          MODE_PASS: begin
            data_d  = bus.in_data;
            state_d = HOLD;
          end
          default: begin
            data_d  = rev_w;
            state_d = HOLD;
          end
        endcase
      end
      COLLECT: if (accept_w) begin
        data_d = ins_w;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      EMIT: if (bus.out_ready) begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: if (bus.out_ready) begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      mode_q  <= MODE_S2P;
      msb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      msb_q   <= msb_d;
    end
  end

  always_comb begin
    bus.out_data = '0;
    if (state_q == HOLD)      bus.out_data = data_q;
    else if (state_q == EMIT) bus.out_data[L-1:0] = chunk_w;
  end

  assign bus.in_ready  = in_rdy_w;
  assign bus.out_valid = (state_q == EMIT) | (state_q == HOLD);
  assign bus.out_last  = (state_q == HOLD) | ((state_q == EMIT) & (cnt_q == LAST));

`ifdef SP_GEARBOX_PARITY_EN
  assign bus.out_parity = bus.out_valid & (^data_q);
`else
`endif

endmodule

// File: tb/tb_sp_gearbox.sv
// tb_sp_gearbox: directed + randomized checks of sp_gearbox.
//   dut_a : N=8, L=1 (S2P, pass, reversed pass, reset mid-word)
//   dut_b : N=8, L=2 (P2S chunking and stalls)
// Expected values come from a word-level model (shift/accumulate, streaming
// reversal, chunk extraction by arithmetic shift).
module tb_sp_gearbox;
  import sp_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  sp_gearbox_if #(.N(N)) ifa ();
  sp_gearbox_if #(.N(N)) ifb ();

  sp_gearbox #(.N(N), .L(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  sp_gearbox #(.N(N), .L(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // S2P with L=1: b[k] is the k-th serial beat.
  function automatic logic [N-1:0] m_s2p1(input logic [7:0] b, input bit msb);
    logic [N-1:0] w = '0;
    for (int k = 0; k < N; k++)
      if (msb) w = {w[N-2:0], b[k]};
      else     w = w | (N'(b[k]) << k);
    return w;
  endfunction

  function automatic logic [N-1:0] m_rev(input logic [N-1:0] w);
    logic [N-1:0] r;
    r = {<<{w}};
    return r;
  endfunction

  // k-th serial chunk of width l taken from word w.
  function automatic logic [N-1:0] m_chunk(input logic [N-1:0] w, input int l,
                                           input bit msb, input int k);
    int sh;
    logic [N-1:0] mask;
    sh   = msb ? N - l*(k+1) : k*l;
    mask = N'((1 << l) - 1);
    return (w >> sh) & mask;
  endfunction

  // ---------------- dut_a helpers ----------------
  task automatic hold_release_a(input logic [N-1:0] exp, input int nstall, input string tag);
    for (int s = 0; s < nstall; s++) begin
      ifa.out_ready = 1'b0;
      ifa.in_valid  = 1'($urandom);
      ifa.in_data   = 8'($urandom);
      ifa.mode      = 2'($urandom);
      step();
      chk({tag, "_hold_data"},  32'(ifa.out_data),  32'(exp));
      chk({tag, "_hold_valid"}, 32'(ifa.out_valid), 32'd1);
      chk({tag, "_hold_last"},  32'(ifa.out_last),  32'd1);
      chk({tag, "_hold_irdy"},  32'(ifa.in_ready),  32'd0);
    end
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
    step();
    ifa.out_ready = 1'b0;
    chk({tag, "_idle_valid"}, 32'(ifa.out_valid), 32'd0);
    chk({tag, "_idle_last"},  32'(ifa.out_last),  32'd0);
    chk({tag, "_idle_data"},  32'(ifa.out_data),  32'd0);
    chk({tag, "_idle_irdy"},  32'(ifa.in_ready),  32'd1);
  endtask

  // scramble: 0 = steady mode, 1 = mode 01 from beat 2 on, 2 = random mode/msb after beat 0
  task automatic run_s2p_a(input logic [7:0] beats, input bit msb, input bit gaps,
                           input int scramble, input int nstall, input string tag);
    logic [N-1:0] exp;
    for (int k = 0; k < N; k++) begin
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          ifa.in_valid = 1'b0;
          ifa.in_data  = 8'($urandom);
          step();
          chk({tag, "_gap_valid"}, 32'(ifa.out_valid), 32'd0);
          chk({tag, "_gap_irdy"},  32'(ifa.in_ready),  32'd1);
        end
      end
      ifa.in_valid  = 1'b1;
      ifa.in_data   = {7'($urandom), beats[k]};
      ifa.mode      = MODE_S2P;
      ifa.msb_first = msb;
      if (scramble == 1 && k >= 2) ifa.mode = MODE_P2S;
      if (scramble == 2 && k >= 1) begin
        ifa.mode      = 2'($urandom);
        ifa.msb_first = 1'($urandom);
      end
      step();
    end
    ifa.in_valid = 1'b0;
    exp = m_s2p1(beats, msb);
    chk({tag, "_word"},  32'(ifa.out_data),  32'(exp));
    chk({tag, "_valid"}, 32'(ifa.out_valid), 32'd1);
    chk({tag, "_last"},  32'(ifa.out_last),  32'd1);
    chk({tag, "_irdy"},  32'(ifa.in_ready),  32'd0);
`ifdef SP_GEARBOX_PARITY_EN
    chk({tag, "_parity"}, 32'(ifa.out_parity), 32'(^exp));
`endif
    hold_release_a(exp, nstall, tag);
  endtask

  task automatic run_pass_a(input logic [N-1:0] w, input bit rev, input int nstall,
                            input string tag);
    logic [N-1:0] exp;
    ifa.mode      = rev ? MODE_REV : MODE_PASS;
    ifa.msb_first = 1'($urandom);
    ifa.in_data   = w;
    ifa.in_valid  = 1'b1;
    step();
    ifa.in_valid = 1'b0;
    exp = rev ? m_rev(w) : w;
    chk({tag, "_word"},  32'(ifa.out_data),  32'(exp));
    chk({tag, "_valid"}, 32'(ifa.out_valid), 32'd1);
    chk({tag, "_last"},  32'(ifa.out_last),  32'd1);
`ifdef SP_GEARBOX_PARITY_EN
    chk({tag, "_parity"}, 32'(ifa.out_parity), 32'(^exp));
`endif
    hold_release_a(exp, nstall, tag);
  endtask

  // ---------------- dut_b (L=2) P2S ----------------
  task automatic run_p2s_b(input logic [N-1:0] w, input bit msb, input bit stalls,
                           input string tag);
    logic [N-1:0] exp;
    ifb.mode      = MODE_P2S;
    ifb.msb_first = msb;
    ifb.in_data   = w;
    ifb.in_valid  = 1'b1;
    step();
    ifb.in_valid  = 1'b0;
    ifb.mode      = 2'($urandom);
    ifb.msb_first = 1'($urandom);
    for (int k = 0; k < N/2; k++) begin
      exp = m_chunk(w, 2, msb, k);
      for (int s = 0; s < (stalls ? int'($urandom_range(0, 2)) : 0); s++) begin
        ifb.out_ready = 1'b0;
        chk({tag, "_stall_data"}, 32'(ifb.out_data), 32'(exp));
        chk({tag, "_stall_irdy"}, 32'(ifb.in_ready), 32'd0);
        step();
      end
      chk({tag, "_chunk"}, 32'(ifb.out_data),  32'(exp));
      chk({tag, "_valid"}, 32'(ifb.out_valid), 32'd1);
      chk({tag, "_last"},  32'(ifb.out_last),  32'(k == N/2 - 1));
`ifdef SP_GEARBOX_PARITY_EN
      chk({tag, "_parity"}, 32'(ifb.out_parity), 32'(^w));
`endif
      ifb.out_ready = 1'b1;
      step();
      ifb.out_ready = 1'b0;
    end
    chk({tag, "_end_valid"}, 32'(ifb.out_valid), 32'd0);
    chk({tag, "_end_irdy"},  32'(ifb.in_ready),  32'd1);
  endtask

  initial begin
    ifa.mode = MODE_S2P; ifa.msb_first = 1'b0; ifa.in_data = '0;
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
    ifb.mode = MODE_S2P; ifb.msb_first = 1'b0; ifb.in_data = '0;
    ifb.in_valid = 1'b0; ifb.out_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_irdy_a",  32'(ifa.in_ready),  32'd0);
    chk("rst_irdy_b",  32'(ifb.in_ready),  32'd0);
    chk("rst_valid_a", 32'(ifa.out_valid), 32'd0);
    chk("rst_last_a",  32'(ifa.out_last),  32'd0);
    chk("rst_data_a",  32'(ifa.out_data),  32'd0);
    chk("rst_valid_b", 32'(ifb.out_valid), 32'd0);
`ifdef SP_GEARBOX_PARITY_EN
    chk("rst_parity_a", 32'(ifa.out_parity), 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("post_rst_irdy_a", 32'(ifa.in_ready), 32'd1);

    // S2P LSB-first, beats 1,0,1,1,0,0,0,1 (bit k = beat k)
    run_s2p_a(8'b1000_1101, 1'b0, 1'b0, 0, 0, "r028");
    // P2S L=2 MSB-first 8'hB4 -> 2,3,1,0
    run_p2s_b(8'hB4, 1'b1, 1'b0, "r029");
    // Reversed pass 8'h01 with 3 stalled cycles
    run_pass_a(8'h01, 1'b1, 3, "r030");

    // Reset after 3 S2P beats, then a clean word
    for (int k = 0; k < 3; k++) begin
      ifa.mode = MODE_S2P; ifa.msb_first = 1'b0;
      ifa.in_valid = 1'b1; ifa.in_data = 8'hFF;
      step();
    end
    ifa.in_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("r031_rst_valid", 32'(ifa.out_valid), 32'd0);
    chk("r031_rst_irdy",  32'(ifa.in_ready),  32'd0);
    rst = 1'b0;
    run_s2p_a(8'h00, 1'b0, 1'b0, 0, 0, "r031_zero");
    run_s2p_a(8'h5A, 1'b0, 1'b1, 0, 1, "r031_word");

    // Mode changed to P2S after beat 2: word still completes as S2P
    run_s2p_a(8'hC3, 1'b0, 1'b0, 1, 0, "r032");
    run_s2p_a(8'h96, 1'b1, 1'b0, 1, 2, "r032_msb");

    // Plain pass and LSB-first P2S
    run_pass_a(8'hA7, 1'b0, 0, "pass");
    run_p2s_b(8'hB4, 1'b0, 1'b1, "p2s_lsb");

    // Randomized words
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: run_s2p_a(8'($urandom), 1'($urandom), 1'b1, 2, int'($urandom_range(0, 2)), "rnd_s2p");
        1: run_pass_a(8'($urandom), 1'b0, int'($urandom_range(0, 2)), "rnd_pass");
        2: run_pass_a(8'($urandom), 1'b1, int'($urandom_range(0, 2)), "rnd_rev");
        default: run_p2s_b(8'($urandom), 1'($urandom), 1'b1, "rnd_p2s");
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
